mem_ctrl_mc: RTL and testbench

- Parametrised multi-channel successor of the fuzzing micro-benchmark memory controller.
- NUM_CH identical request channels each assemble a BEATS-beat packet through a READY/PENDING/BUSY FSM.
- A round-robin arbiter drains BUSY channels to one output under a valid/ready handshake.
- Built-in instrumentation for coverage-guided fuzzing: a state-tuple coverage map with a running sum, per-signal sticky toggle flags, and a bug flag.

---
 rtl/mem_ctrl_mc_pkg.sv | 23 ++
 rtl/mem_ctrl_mc_if.sv | 19 +
 rtl/mem_ctrl_mc_chan.sv | 34 +++
 rtl/mem_ctrl_mc.sv | 90 +++++++++
 tb/tb_mem_ctrl_mc.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_mc_pkg.sv
// mem_ctrl_mc_pkg: shared constants and helpers for the multi-channel memory controller
package mem_ctrl_mc_pkg;
   localparam int READY = 0;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic int busy_st(input int beats);
      return beats;
   endfunction

   // XOR-fold v into cov_w-bit chunks; bits beyond the vector are zero so padding is free
   function automatic logic [31:0] cov_fold(input logic [63:0] v, input int cov_w);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 64; i++) r[5'(i % cov_w)] ^= v[i];
      return r;
   endfunction
endpackage

// File: rtl/mem_ctrl_mc_if.sv
// mem_ctrl_mc_if: per-channel request beats and arbitrated packet output
interface mem_ctrl_mc_if #(
   parameter int NUM_CH = 3,
   parameter int BEATS = 3,
   parameter int DW = 2
);
   import mem_ctrl_mc_pkg::*;
   localparam int PW = BEATS * DW;
   localparam int CW = clog2(NUM_CH);
   logic [NUM_CH-1:0] ch_valid;
   logic [NUM_CH*DW-1:0] ch_data;
   logic [NUM_CH-1:0] ch_ready;
   logic out_ready;
   logic out_valid;
   logic [PW-1:0] out_data;
   logic [CW-1:0] out_ch;
   modport master (output ch_valid, ch_data, out_ready, input ch_ready, out_valid, out_data, out_ch);
   modport slave (input ch_valid, ch_data, out_ready, output ch_ready, out_valid, out_data, out_ch);
endinterface

// File: rtl/mem_ctrl_mc_chan.sv
// mem_chan: one request channel; counts beats READY->PENDING_k->BUSY and assembles the packet
module mem_chan import mem_ctrl_mc_pkg::*; #(
   parameter int BEATS = 3,
   parameter int DW = 2,
   localparam int SW = clog2(BEATS + 1),
   localparam int PW = BEATS * DW
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          valid,
   input  logic [DW-1:0] data,
   input  logic          grant_xfer,
   output logic          ready,
   output logic          busy,
   output logic [SW-1:0] cnt,
   output logic [PW-1:0] pkt
);
   assign busy = cnt == SW'(busy_st(BEATS));
   assign ready = !busy;

   // a missing beat while pending aborts; pkt is left stale since it is only read when BUSY
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         cnt <= SW'(READY);
         pkt <= '0;
      end else if (busy) begin
         cnt <= grant_xfer ? SW'(READY) : cnt;
      end else if (valid) begin
         cnt <= cnt + 1'b1;
         pkt <= (cnt == SW'(READY)) ? PW'(data) : pkt | (PW'(data) << (cnt * DW));
      end else begin
         cnt <= SW'(READY);
      end
endmodule

// File: rtl/mem_ctrl_mc.sv
// mem_ctrl_mc: multi-channel packet assembler with round-robin output and fuzzing instrumentation
module mem_ctrl_mc import mem_ctrl_mc_pkg::*; #(
   parameter int NUM_CH = 3,
   parameter int BEATS = 3,
   parameter int DW = 2,
   parameter int COV_W = 6
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  meta_reset,
   mem_ctrl_mc_if.slave          bus,
   output logic [3*NUM_CH-1:0]   coverage,
   output logic [COV_W:0]        io_cov_sum,
   output logic                  bug
);
   localparam int SW = clog2(BEATS + 1);
   localparam int PW = BEATS * DW;
   localparam int CW = clog2(NUM_CH);

   logic [NUM_CH-1:0] busy, xfer_ch;
   logic [SW-1:0] cnt [NUM_CH];
   logic [PW-1:0] pkt [NUM_CH];
   logic [NUM_CH*SW-1:0] cnt_vec;
   logic [CW-1:0] rr_ptr, gnt, j;
   logic xfer;
   logic [3*NUM_CH-1:0] mon, last, primed;
   logic [COV_W-1:0] reg_state;
   logic [2**COV_W-1:0] covmap;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      mem_chan #(.BEATS(BEATS), .DW(DW)) u_chan (
         .clock(clock),
         .reset(reset),
         .valid(bus.ch_valid[i]),
         .data(bus.ch_data[i*DW +: DW]),
         .grant_xfer(xfer_ch[i]),
         .ready(bus.ch_ready[i]),
         .busy(busy[i]),
         .cnt(cnt[i]),
         .pkt(pkt[i])
      );
      assign cnt_vec[i*SW +: SW] = cnt[i];
      assign xfer_ch[i] = xfer && gnt == CW'(i);
      assign mon[3*i +: 3] = {cnt[i] == SW'(READY), busy[i], bus.ch_valid[i]};
   end

   // scan from the farthest offset down so the nearest BUSY channel at/after rr_ptr wins
   always_comb begin
      gnt = rr_ptr;
      j = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         j = CW'((int'(rr_ptr) + k) % NUM_CH);
         if (busy[j]) gnt = j;
      end
   end

   assign bug = &busy;
   assign bus.out_valid = |busy;
   assign xfer = bus.out_valid && bus.out_ready;
   assign bus.out_data = bus.out_valid ? pkt[gnt] : '0;
   assign bus.out_ch = bus.out_valid ? gnt : '0;

   always_ff @(posedge clock or negedge reset)
      if (!reset) rr_ptr <= '0;
      else if (xfer) rr_ptr <= (gnt == CW'(NUM_CH - 1)) ? '0 : gnt + 1'b1;

   // the first cycle after reset only captures a baseline so release itself is not a toggle
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         last <= '0;
         primed <= '0;
         coverage <= '0;
      end else begin
         last <= mon;
         primed <= '1;
         coverage <= coverage | (primed & (mon ^ last));
      end

   // instrumentation survives functional reset so coverage accumulates across fuzz runs
   always_ff @(posedge clock) begin
      reg_state <= COV_W'(cov_fold(64'(cnt_vec), COV_W));
      if (meta_reset) begin
         covmap <= '0;
         io_cov_sum <= '0;
      end else if (!covmap[reg_state]) begin
         covmap[reg_state] <= 1'b1;
         io_cov_sum <= io_cov_sum + 1'b1;
      end
   end
endmodule

// File: tb/tb_mem_ctrl_mc.sv
// tb_mem_ctrl_mc: directed stimulus with a queue scoreboard checked by an output monitor
module tb_mem_ctrl_mc;
   logic clock = 1'b0;
   logic reset = 1'b0;
   logic meta_reset = 1'b1;
   logic [8:0] coverage;
   logic [6:0] io_cov_sum;
   logic bug;
   logic [6:0] cs;
   int total = 0;
   int bad = 0;

   typedef struct packed {
      logic [1:0] ch;
      logic [5:0] d;
   } exp_t;
   exp_t q[$];
   exp_t e;

   mem_ctrl_mc_if #(.NUM_CH(3), .BEATS(3), .DW(2)) bus();

   mem_ctrl_mc #(.NUM_CH(3), .BEATS(3), .DW(2), .COV_W(6)) dut (
      .clock(clock),
      .reset(reset),
      .meta_reset(meta_reset),
      .bus(bus.slave),
      .coverage(coverage),
      .io_cov_sum(io_cov_sum),
      .bug(bug)
   );

   always #5 clock = ~clock;

   initial begin
      #50000;
      $display("FAIL timeout");
      $fatal(1);
   end

   always @(negedge clock)
      if (reset && bus.out_valid && bus.out_ready) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected got ch=%0d data=%0h exp none", bus.out_ch, bus.out_data);
         end else begin
            e = q.pop_front();
            if (bus.out_ch !== e.ch || bus.out_data !== e.d) begin
               bad++;
               $display("FAIL sb_pkt got ch=%0d data=%0h exp ch=%0d data=%0h", bus.out_ch, bus.out_data, e.ch, e.d);
            end
         end
      end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", n, got, exp);
      end
   endtask

   task automatic drive(input logic [2:0] v, input logic [5:0] d);
      bus.ch_valid = v;
      bus.ch_data = d;
      tick();
   endtask

   task automatic push(input logic [1:0] ch, input logic [5:0] d);
      exp_t x;
      x.ch = ch;
      x.d = d;
      q.push_back(x);
   endtask

   initial begin
      bus.ch_valid = '0;
      bus.ch_data = '0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      chk("rst_ch_ready", 32'(bus.ch_ready), 32'h7);
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_out_data", 32'(bus.out_data), 32'h0);
      chk("rst_out_ch", 32'(bus.out_ch), 32'h0);
      chk("rst_bug", 32'(bug), 32'h0);
      chk("rst_coverage", 32'(coverage), 32'h0);
      reset = 1'b1;
      meta_reset = 1'b0;

      // single ch0 packet 1,2,3
      bus.out_ready = 1'b1;
      drive(3'b001, 6'd1);
      drive(3'b001, 6'd2);
      push(2'd0, 6'h39);
      drive(3'b001, 6'd3);
      chk("t1_out_valid", 32'(bus.out_valid), 32'h1);
      chk("t1_out_ch", 32'(bus.out_ch), 32'h0);
      chk("t1_out_data", 32'(bus.out_data), 32'h39);
      chk("t1_ch_ready_busy", 32'(bus.ch_ready), 32'h6);
      drive(3'b000, 6'd0);
      chk("t1_ch_ready_after", 32'(bus.ch_ready), 32'h7);
      chk("t1_out_valid_after", 32'(bus.out_valid), 32'h0);

      // ch1 aborted after 2 beats, then 0,0,1
      drive(3'b010, 6'b000100);
      drive(3'b010, 6'b001000);
      chk("t2_pend_ready", 32'(bus.ch_ready), 32'h7);
      drive(3'b000, 6'd0);
      chk("t2_abort_valid", 32'(bus.out_valid), 32'h0);
      drive(3'b010, 6'd0);
      drive(3'b010, 6'd0);
      chk("t2_no_early_valid", 32'(bus.out_valid), 32'h0);
      push(2'd1, 6'h10);
      drive(3'b010, 6'b000100);
      chk("t2_out_ch", 32'(bus.out_ch), 32'h1);
      chk("t2_out_data", 32'(bus.out_data), 32'h10);
      drive(3'b000, 6'd0);
      chk("t2_idle", 32'(bus.out_valid), 32'h0);

      // rewind rr_ptr, then fill all channels while blocked
      reset = 1'b0;
      #1;
      reset = 1'b1;
      bus.out_ready = 1'b0;
      drive(3'b111, 6'b111001);
      drive(3'b111, 6'b001001);
      push(2'd0, 6'h15);
      push(2'd1, 6'h2A);
      push(2'd2, 6'h13);
      drive(3'b111, 6'b011001);
      chk("t3_bug", 32'(bug), 32'h1);
      chk("t3_ch_ready", 32'(bus.ch_ready), 32'h0);
      chk("t3_out_ch0", 32'(bus.out_ch), 32'h0);
      drive(3'b111, 6'h3F);
      chk("t3_ignore_data", 32'(bus.out_data), 32'h15);
      chk("t3_bug_hold", 32'(bug), 32'h1);
      bus.ch_valid = '0;
      bus.out_ready = 1'b1;
      tick();
      chk("t3_out_ch1", 32'(bus.out_ch), 32'h1);
      chk("t3_bug_drop", 32'(bug), 32'h0);
      chk("t3_data1", 32'(bus.out_data), 32'h2A);
      tick();
      chk("t3_out_ch2", 32'(bus.out_ch), 32'h2);
      chk("t3_data2", 32'(bus.out_data), 32'h13);
      tick();
      chk("t3_drained", 32'(bus.out_valid), 32'h0);

      // ch0 transfer moves rr_ptr to 1, so ch2 beats ch0
      drive(3'b001, 6'd3);
      drive(3'b001, 6'd3);
      push(2'd0, 6'h3F);
      drive(3'b001, 6'd3);
      drive(3'b000, 6'd0);
      bus.out_ready = 1'b0;
      drive(3'b101, 6'b100000);
      drive(3'b101, 6'b000001);
      push(2'd2, 6'h02);
      push(2'd0, 6'h04);
      drive(3'b101, 6'b000000);
      chk("t4_first_ch2", 32'(bus.out_ch), 32'h2);
      chk("t4_data_ch2", 32'(bus.out_data), 32'h02);
      bus.ch_valid = '0;
      bus.out_ready = 1'b1;
      tick();
      chk("t4_then_ch0", 32'(bus.out_ch), 32'h0);
      chk("t4_data_ch0", 32'(bus.out_data), 32'h04);
      tick();
      chk("t4_idle", 32'(bus.out_valid), 32'h0);

      // async reset with ch0 BUSY and ch2 PENDING
      bus.out_ready = 1'b0;
      drive(3'b001, 6'd1);
      drive(3'b001, 6'd1);
      drive(3'b001, 6'd1);
      drive(3'b100, 6'b010000);
      chk("t5_pre_busy", 32'(bus.out_valid), 32'h1);
      cs = io_cov_sum;
      bus.ch_valid = '0;
      reset = 1'b0;
      #1;
      chk("t5_out_valid", 32'(bus.out_valid), 32'h0);
      chk("t5_ch_ready", 32'(bus.ch_ready), 32'h7);
      chk("t5_out_data", 32'(bus.out_data), 32'h0);
      chk("t5_bug", 32'(bug), 32'h0);
      chk("t5_covsum_kept", 32'(io_cov_sum), 32'(cs));
      reset = 1'b1;
      tick();
      chk("t5_discarded", 32'(bus.out_valid), 32'h0);

      // coverage map and toggle flags
      meta_reset = 1'b1;
      tick();
      meta_reset = 1'b0;
      tick();
      tick();
      tick();
      chk("t6_covsum_idle", 32'(io_cov_sum), 32'h1);
      bus.out_ready = 1'b1;
      drive(3'b001, 6'd1);
      drive(3'b001, 6'd1);
      push(2'd0, 6'h15);
      drive(3'b001, 6'd1);
      drive(3'b000, 6'd0);
      tick();
      tick();
      tick();
      chk("t6_covsum_walk", 32'(io_cov_sum), 32'h4);
      chk("t6_coverage", 32'(coverage), 32'h007);

      chk("sb_drain", 32'(q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
